mem_bus_arbiter: RTL and testbench

- Two-port arbiter sharing one native valid/ready memory port between the multicycle CPU core (port 0) and a secondary master such as a DMA or video fetcher (port 1).
- Sits between the core's mem_* bus and the SoC memory/peripheral interconnect.
- Round-robin arbitration with one-cycle decision latency.
- Per-transaction watchdog returns access_fault to the owning master if the slave never answers.

---
 rtl/mem_arb_pkg.sv | 37 +++
 rtl/bus_watchdog.sv | 42 ++++
 rtl/mem_bus_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_bus_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory bus arbiter and its watchdog.
// Holds the state/owner encodings, the watchdog width and the arbitration helper.
package mem_arb_pkg;

  localparam logic ARB_IDLE = 1'b0;
  localparam logic ARB_BUSY = 1'b1;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_AUX = 1'b1;

  localparam int unsigned WDOG_WIDTH = 16;

  typedef enum logic {
    StIdle = ARB_IDLE,
    StBusy = ARB_BUSY
  } arb_state_e;

  typedef struct packed {
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_req_t;

  // Round-robin pick: a lone requester wins, a tie goes to whoever did not go last.
  function automatic logic arb_pick(input logic v0, input logic v1, input logic last_owner);
    logic pick;
    if (v0 && v1) begin
      pick = ~last_owner;
    end else if (v1) begin
      pick = OWNER_AUX;
    end else begin
      pick = OWNER_CPU;
    end
    return pick;
  endfunction

endpackage

// File: rtl/bus_watchdog.sv
// Saturating transaction watchdog: cleared while idle, counts while enabled,
// flags expiry on the TIMEOUT_CYCLES-th enabled cycle.
module bus_watchdog
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned Width          = WDOG_WIDTH
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [Width-1:0] CountMax = '1;
  localparam logic [Width-1:0] CountOne = Width'(1);
  localparam logic [Width-1:0] ExpireAt = Width'(TIMEOUT_CYCLES - 1);

  logic [Width-1:0] count_q, count_d;

  // Clear has priority; the count holds at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && (count_q != CountMax)) begin
      count_d = count_q + CountOne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = enable_i && (count_q == ExpireAt);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory port between the CPU (port 0)
// and an auxiliary master (port 1), with a per-transaction watchdog.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter bit          TIMEOUT_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_access_fault,

  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_access_fault,

  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_access_fault,

  output logic [1:0]  busy_owner
);

  arb_state_e state_q, state_d;
  logic       owner_q, owner_d;
  logic       last_owner_q, last_owner_d;

  logic       busy;
  logic       owner_valid;
  logic       wdog_expire;
  logic       timeout;
  logic       done;
  logic       fault;
  mem_req_t   req0, req1, req_sel;

  assign req0 = '{wstrb: m0_wstrb, addr: m0_addr, wdata: m0_wdata};
  assign req1 = '{wstrb: m1_wstrb, addr: m1_addr, wdata: m1_wdata};

  assign busy        = (state_q == StBusy);
  assign owner_valid = (owner_q == OWNER_AUX) ? m1_valid : m0_valid;
  assign req_sel     = (owner_q == OWNER_AUX) ? req1 : req0;

  // A slave answer in the expiry cycle still completes normally.
  assign timeout = TIMEOUT_EN && wdog_expire && !mem_ready;

  bus_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .Width         (WDOG_WIDTH)
  ) u_wdog (
    .clk_i   (clk),
    .rst_ni  (resetn),
    .clear_i (!busy),
    .enable_i(busy),
    .expire_o(wdog_expire)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    done         = 1'b0;
    fault        = 1'b0;

    case (state_q)
      StIdle: begin
        if (m0_valid || m1_valid) begin
          owner_d = arb_pick(m0_valid, m1_valid, last_owner_q);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (!owner_valid) begin
          // Master withdrew its request: drop it silently, fairness unchanged.
          state_d = StIdle;
        end else if (mem_ready) begin
          done         = 1'b1;
          fault        = mem_access_fault;
          state_d      = StIdle;
          last_owner_d = owner_q;
        end else if (timeout) begin
          done         = 1'b1;
          fault        = 1'b1;
          state_d      = StIdle;
          last_owner_d = owner_q;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      owner_q      <= OWNER_CPU;
      last_owner_q <= OWNER_AUX;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
    end
  end

  assign mem_valid = busy;
  assign mem_wstrb = busy ? req_sel.wstrb : '0;
  assign mem_addr  = busy ? req_sel.addr  : '0;
  assign mem_wdata = busy ? req_sel.wdata : '0;

  assign m0_ready        = done && (owner_q == OWNER_CPU);
  assign m1_ready        = done && (owner_q == OWNER_AUX);
  assign m0_access_fault = done && fault && (owner_q == OWNER_CPU);
  assign m1_access_fault = done && fault && (owner_q == OWNER_AUX);

  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  assign busy_owner = {busy, busy & owner_q};

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter: expected completions are queued as
// requests are issued and retired as the DUT pulses ready.
module tb_mem_bus_arbiter;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_valid, m0_ready, m0_access_fault;
  logic [3:0]  m0_wstrb;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_valid, m1_ready, m1_access_fault;
  logic [3:0]  m1_wstrb;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        mem_valid, mem_ready, mem_access_fault;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  busy_owner;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES(TO),
    .TIMEOUT_EN    (1'b1)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .m0_valid        (m0_valid),
    .m0_ready        (m0_ready),
    .m0_wstrb        (m0_wstrb),
    .m0_addr         (m0_addr),
    .m0_wdata        (m0_wdata),
    .m0_rdata        (m0_rdata),
    .m0_access_fault (m0_access_fault),
    .m1_valid        (m1_valid),
    .m1_ready        (m1_ready),
    .m1_wstrb        (m1_wstrb),
    .m1_addr         (m1_addr),
    .m1_wdata        (m1_wdata),
    .m1_rdata        (m1_rdata),
    .m1_access_fault (m1_access_fault),
    .mem_valid       (mem_valid),
    .mem_ready       (mem_ready),
    .mem_wstrb       (mem_wstrb),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_access_fault(mem_access_fault),
    .busy_owner      (busy_owner)
  );

  // lat: BUSY cycles before the slave answers (0 = first BUSY cycle), -1 = never.
  typedef struct {
    logic        port;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    int          lat;
    logic        flt;
    logic [31:0] rd;
  } txn_t;

  txn_t sb_q[$];
  txn_t pend0[$];
  txn_t pend1[$];

  int   total = 0;
  int   bad = 0;
  int   busy_cnt = 0;
  logic prev_ready = 1'b0;
  logic done0 = 1'b0;
  logic done1 = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic port, input txn_t t);
    if (port) begin
      m1_valid = 1'b1; m1_addr = t.addr; m1_wstrb = t.wstrb; m1_wdata = t.wdata;
    end else begin
      m0_valid = 1'b1; m0_addr = t.addr; m0_wstrb = t.wstrb; m0_wdata = t.wdata;
    end
  endtask

  task automatic idle_port(input logic port);
    if (port) begin
      m1_valid = 1'b0; m1_addr = '0; m1_wstrb = '0; m1_wdata = '0;
    end else begin
      m0_valid = 1'b0; m0_addr = '0; m0_wstrb = '0; m0_wdata = '0;
    end
  endtask

  task automatic req(input logic port, input logic [31:0] addr, input logic [3:0] wstrb,
                     input logic [31:0] wdata, input int lat, input logic flt,
                     input logic [31:0] rd);
    txn_t t;
    t = '{port: port, addr: addr, wstrb: wstrb, wdata: wdata, lat: lat, flt: flt, rd: rd};
    sb_q.push_back(t);
    if (port) begin
      if (!m1_valid) drive(1'b1, t);
      else pend1.push_back(t);
    end else begin
      if (!m0_valid) drive(1'b0, t);
      else pend0.push_back(t);
    end
  endtask

  task automatic sb_check();
    txn_t e;
    if (prev_ready) chk("idle_after_done", {31'd0, mem_valid}, 32'd0);
    prev_ready = m0_ready | m1_ready;
    if (mem_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_busy", {31'd0, mem_valid}, 32'd0);
      end else begin
        e = sb_q[0];
        chk("busy_owner", {30'd0, busy_owner}, {30'd0, 1'b1, e.port});
        chk("mem_addr", mem_addr, e.addr);
        chk("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e.wstrb});
        chk("mem_wdata", mem_wdata, e.wdata);
      end
    end
    if (m0_ready || m1_ready) begin
      chk("dual_ready", {31'd0, m0_ready & m1_ready}, 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_ready", {31'd0, m0_ready | m1_ready}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("ready_port", {31'd0, m1_ready}, {31'd0, e.port});
        chk("done_cycle", busy_cnt, (e.lat < 0) ? TO : e.lat + 1);
        chk("owner_fault", {31'd0, e.port ? m1_access_fault : m0_access_fault},
            {31'd0, (e.lat < 0) | e.flt});
        chk("other_fault", {31'd0, e.port ? m0_access_fault : m1_access_fault}, 32'd0);
        chk("owner_rdata", e.port ? m1_rdata : m0_rdata, e.rd);
        if (m0_ready) done0 = 1'b1;
        if (m1_ready) done1 = 1'b1;
      end
    end else begin
      chk("fault_no_ready", {31'd0, m0_access_fault | m1_access_fault}, 32'd0);
    end
  endtask

  // One clock: slave reacts, outputs checked, then masters advance past the edge.
  task automatic cycle();
    txn_t e;
    #1;
    if (mem_valid && sb_q.size() != 0) begin
      e = sb_q[0];
      mem_ready        = (e.lat >= 0) && (busy_cnt == e.lat);
      mem_access_fault = mem_ready && e.flt;
      mem_rdata        = e.rd;
      busy_cnt++;
    end else begin
      mem_ready        = 1'b0;
      mem_access_fault = 1'b0;
      busy_cnt         = mem_valid ? busy_cnt + 1 : 0;
    end
    #1;
    sb_check();
    @(posedge clk);
    #1;
    if (done0) begin
      done0 = 1'b0;
      if (pend0.size() != 0) drive(1'b0, pend0.pop_front());
      else idle_port(1'b0);
    end
    if (done1) begin
      done1 = 1'b0;
      if (pend1.size() != 0) drive(1'b1, pend1.pop_front());
      else idle_port(1'b1);
    end
  endtask

  task automatic run(input int maxc);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < maxc) begin
      cycle();
      n++;
    end
    chk("run_bound", sb_q.size(), 32'd0);
    cycle();
  endtask

  initial begin
    // Reset with every input active: outputs must still be quiet.
    resetn = 1'b0;
    m0_valid = 1'b1; m0_addr = '1; m0_wstrb = '1; m0_wdata = '1;
    m1_valid = 1'b1; m1_addr = '1; m1_wstrb = '1; m1_wdata = '1;
    mem_ready = 1'b1; mem_access_fault = 1'b1; mem_rdata = 32'h1234_5678;
    #12;
    chk("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("rst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("rst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("rst_faults", {30'd0, m0_access_fault, m1_access_fault}, 32'd0);
    chk("rst_busy_owner", {30'd0, busy_owner}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    chk("rst_m0_rdata", m0_rdata, 32'h1234_5678);
    chk("rst_m1_rdata", m1_rdata, 32'h1234_5678);
    idle_port(1'b0);
    idle_port(1'b1);
    mem_ready = 1'b0; mem_access_fault = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // Both masters requesting from reset: grants alternate 0,1,0,1.
    req(1'b0, 32'h8000_0000, 4'h0, 32'h0, 0, 1'b0, 32'hA000_0001);
    req(1'b1, 32'h2000_0000, 4'h0, 32'h0, 0, 1'b0, 32'hB000_0001);
    req(1'b0, 32'h8000_0004, 4'hF, 32'h0101_0101, 0, 1'b0, 32'hA000_0002);
    req(1'b1, 32'h2000_0004, 4'hF, 32'h0202_0202, 0, 1'b0, 32'hB000_0002);
    run(30);

    // Single CPU read, slave answers in the third BUSY cycle.
    req(1'b0, 32'h8000_0010, 4'h0, 32'h0, 2, 1'b0, 32'hDEAD_BEEF);
    chk("t1_decide_cycle", {31'd0, mem_valid}, 32'd0);
    cycle();
    chk("t1_rise", {31'd0, mem_valid}, 32'd1);
    run(20);

    // Port 1 write passthrough.
    req(1'b1, 32'h1000_0000, 4'b0011, 32'h0000_A5A5, 1, 1'b0, 32'h0);
    run(20);

    // Watchdog expiry on an unanswered CPU read; port 1 is served afterwards.
    req(1'b0, 32'h8000_0020, 4'h0, 32'h0, -1, 1'b0, 32'hCAFE_0000);
    req(1'b1, 32'h2000_0000, 4'hF, 32'h1111_2222, 0, 1'b0, 32'h0);
    run(40);

    // Slave-reported fault on port 1.
    req(1'b1, 32'h3000_0004, 4'h0, 32'h0, 1, 1'b1, 32'hBAD0_BAD0);
    run(20);

    // Make port 0 the last owner so a tie would favour port 1.
    req(1'b0, 32'h8000_0100, 4'h0, 32'h0, 0, 1'b0, 32'h0000_0001);
    run(20);

    // Tie goes to port 1; reset lands in its second BUSY cycle while the slave answers.
    req(1'b1, 32'h4000_0000, 4'h0, 32'h0, 5, 1'b0, 32'h0);
    req(1'b0, 32'h8000_0200, 4'h0, 32'h0, 5, 1'b0, 32'h0);
    cycle();
    cycle();
    mem_ready = 1'b1;
    #1;
    resetn = 1'b0;
    #1;
    chk("midrst_mem_valid", {31'd0, mem_valid}, 32'd0);
    chk("midrst_m0_ready", {31'd0, m0_ready}, 32'd0);
    chk("midrst_m1_ready", {31'd0, m1_ready}, 32'd0);
    chk("midrst_busy_owner", {30'd0, busy_owner}, 32'd0);
    sb_q.delete(); pend0.delete(); pend1.delete();
    idle_port(1'b0);
    idle_port(1'b1);
    mem_ready = 1'b0; mem_access_fault = 1'b0;
    busy_cnt = 0; prev_ready = 1'b0; done0 = 1'b0; done1 = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;

    // After reset the first tie belongs to port 0 again.
    req(1'b0, 32'h8000_0300, 4'h0, 32'h0, 0, 1'b0, 32'h0000_0300);
    req(1'b1, 32'h4000_0010, 4'h0, 32'h0, 0, 1'b0, 32'h0000_0010);
    run(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
